t05_htree_node_builder: RTL and testbench

- Huffman tree-merge stage, directly downstream of the least-value finder.
- Each time the finder completes a scan, this block consumes the two smallest entries (`least1`, `least2`) and their `sum`.
- It zeroes both consumed entries in SRAM, writes a new internal node record to the node table, and writes `sum` into a fresh sum slot so the next scan sees it.
- It then signals the controller to rescan. When only one entry remains it reports the tree root.

---
 rtl/t05_huff_pkg.sv | 17 +
 rtl/t05_sram_wr_port.sv | 43 ++++
 rtl/t05_htree_node_builder.sv | 150 +++++++++++++++
 tb/tb_t05_htree_node_builder.sv | 236 +++++++++++++++++++++++
 4 files changed

// File: rtl/t05_huff_pkg.sv
// t05_huff_pkg: shared types and constants for the Huffman tree-building stages
package t05_huff_pkg;
  typedef enum logic [2:0] {S_IDLE, S_CHECK, S_WIPE1, S_WIPE2, S_NODE, S_SUMW, S_DONE} state_e;
  localparam logic [8:0] NONE_IDX = 9'd384;
  localparam logic [9:0] SUM_BASE = 10'd256;
  localparam logic [9:0] NODE_BASE = 10'd512;
  localparam int NODE_MAX = 128;
  typedef struct packed {
    logic [8:0] left;
    logic [8:0] right;
    logic [45:0] weight;
  } node_rec_t;
  // leaves live at their char address, internal nodes in the sum-slot region
  function automatic logic [9:0] entry_addr(input logic [8:0] e);
    return e[8] ? SUM_BASE + {2'b0, e[7:0]} : {2'b0, e[7:0]};
  endfunction
endpackage

// File: rtl/t05_sram_wr_port.sv
// t05_sram_wr_port: holds one SRAM write request stable until acked; done pulses the cycle after ack
module t05_sram_wr_port #(
  parameter int AW = 10,
  parameter int DW = 64
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          clr,
  input  logic          req,
  input  logic [AW-1:0] req_addr,
  input  logic [DW-1:0] req_data,
  input  logic          mem_ack,
  output logic          mem_wr_en,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  output logic          done
);
  logic wr_en_q, wr_en_d, done_q, done_d;
  logic [AW-1:0] addr_q, addr_d;
  logic [DW-1:0] data_q, data_d;
  always_comb begin
    wr_en_d = clr ? 1'b0 : req ? 1'b1 : wr_en_q && !mem_ack;
    done_d = !clr && wr_en_q && mem_ack;
    addr_d = req ? req_addr : addr_q;
    data_d = req ? req_data : data_q;
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      wr_en_q <= 1'b0;
      done_q <= 1'b0;
      addr_q <= '0;
      data_q <= '0;
    end else begin
      wr_en_q <= wr_en_d;
      done_q <= done_d;
      addr_q <= addr_d;
      data_q <= data_d;
    end
  assign mem_wr_en = wr_en_q;
  assign mem_addr = addr_q;
  assign mem_wdata = data_q;
  assign done = done_q;
endmodule

// File: rtl/t05_htree_node_builder.sv
// t05_htree_node_builder: Huffman merge stage - wipes the two consumed entries, writes a node record and a new sum slot.
// Define T05_HTREE_SUM_SAT_EN to saturate the 46-bit node weight and flag sum_sat.
module t05_htree_node_builder
  import t05_huff_pkg::*;
#(
  parameter logic [3:0] STATE_ID = 4'd3
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [3:0]  en_state,
  input  logic [8:0]  least1,
  input  logic [8:0]  least2,
  input  logic [63:0] sum,
  output logic        mem_wr_en,
  output logic [9:0]  mem_addr,
  output logic [63:0] mem_wdata,
  input  logic        mem_ack,
  output logic        fin_state,
  output logic        tree_done,
  output logic [8:0]  root_node,
  output logic [7:0]  node_count,
  output logic        err_overflow,
  output logic        sum_sat
);
  state_e state_q, state_d;
  logic [8:0] l1_q, l1_d, l2_q, l2_d, root_q, root_d;
  logic [63:0] sum_q, sum_d, req_data;
  logic [7:0] count_q, count_d;
  logic tree_done_q, tree_done_d, err_q, err_d, sat_q, sat_d, fin_q, fin_d;
  logic active, req, wp_done, ovf;
  logic [9:0] req_addr;
  node_rec_t rec;
`ifdef T05_HTREE_SUM_SAT_EN
  assign ovf = |sum_q[63:46];
`else
  assign ovf = 1'b0;
`endif
  assign active = en_state == STATE_ID;
  always_comb begin
    rec.left = l1_q;
    rec.right = l2_q;
    rec.weight = ovf ? '1 : sum_q[45:0];
    // request is issued from the state preceding the write it belongs to
    req_addr = state_q == S_CHECK ? entry_addr(l1_q) :
               state_q == S_WIPE1 ? entry_addr(l2_q) :
               state_q == S_WIPE2 ? NODE_BASE + {2'b0, count_q} : SUM_BASE + {2'b0, count_q};
    req_data = state_q == S_WIPE2 ? rec : state_q == S_NODE ? sum_q : '0;
  end
  always_comb begin
    state_d = state_q;
    l1_d = l1_q;
    l2_d = l2_q;
    sum_d = sum_q;
    root_d = root_q;
    count_d = count_q;
    tree_done_d = tree_done_q;
    err_d = err_q;
    sat_d = sat_q;
    req = 1'b0;
    if (!active) state_d = S_IDLE;
    else
      case (state_q)
        S_IDLE: begin
          l1_d = least1;
          l2_d = least2;
          sum_d = sum;
          state_d = S_CHECK;
        end
        S_CHECK:
          if (tree_done_q) state_d = S_DONE;
          else if (l2_q == NONE_IDX) begin
            tree_done_d = 1'b1;
            root_d = l1_q;
            state_d = S_DONE;
          end else if (count_q == 8'(NODE_MAX)) begin
            err_d = 1'b1;
            state_d = S_DONE;
          end else begin
            req = 1'b1;
            state_d = S_WIPE1;
          end
        S_WIPE1:
          if (wp_done) begin
            req = 1'b1;
            state_d = S_WIPE2;
          end
        S_WIPE2:
          if (wp_done) begin
            req = 1'b1;
            sat_d = sat_q | ovf;
            state_d = S_NODE;
          end
        S_NODE:
          if (wp_done) begin
            req = 1'b1;
            state_d = S_SUMW;
          end
        S_SUMW:
          if (wp_done) begin
            count_d = count_q + 8'd1;
            state_d = S_DONE;
          end
        default: state_d = state_q;
      endcase
    fin_d = active && state_d == S_DONE;
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state_q <= S_IDLE;
      l1_q <= '0;
      l2_q <= '0;
      sum_q <= '0;
      root_q <= NONE_IDX;
      count_q <= '0;
      tree_done_q <= 1'b0;
      err_q <= 1'b0;
      sat_q <= 1'b0;
      fin_q <= 1'b0;
    end else begin
      state_q <= state_d;
      l1_q <= l1_d;
      l2_q <= l2_d;
      sum_q <= sum_d;
      root_q <= root_d;
      count_q <= count_d;
      tree_done_q <= tree_done_d;
      err_q <= err_d;
      sat_q <= sat_d;
      fin_q <= fin_d;
    end
  t05_sram_wr_port #(.AW(10), .DW(64)) u_wr_port (
    .clk(clk),
    .rst(rst),
    .clr(!active),
    .req(req),
    .req_addr(req_addr),
    .req_data(req_data),
    .mem_ack(mem_ack),
    .mem_wr_en(mem_wr_en),
    .mem_addr(mem_addr),
    .mem_wdata(mem_wdata),
    .done(wp_done)
  );
  assign fin_state = fin_q;
  assign tree_done = tree_done_q;
  assign root_node = root_q;
  assign node_count = count_q;
  assign err_overflow = err_q;
  assign sum_sat = sat_q;
endmodule

// File: tb/tb_t05_htree_node_builder.sv
// tb_t05_htree_node_builder: randomized scoreboard bench for the Huffman merge stage
module tb_t05_htree_node_builder;
  localparam logic [8:0] NONE = 9'd384;
  logic clk, rst, mem_wr_en, mem_ack, fin_state, tree_done, err_overflow, sum_sat;
  logic [3:0] en_state;
  logic [8:0] least1, least2, root_node;
  logic [63:0] sum, mem_wdata;
  logic [9:0] mem_addr;
  logic [7:0] node_count;
  int n_checks = 0, n_pass = 0;
  logic [73:0] exp_q[$];
  int delays[$];
  int extra = 0, m_count = 0;
  bit rand_delay = 0, spurious = 1, m_done = 0, m_err = 0, m_sat = 0;
  logic [8:0] m_root = NONE;

  t05_htree_node_builder dut (
    .clk(clk), .rst(rst), .en_state(en_state), .least1(least1), .least2(least2), .sum(sum),
    .mem_wr_en(mem_wr_en), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_ack(mem_ack),
    .fin_state(fin_state), .tree_done(tree_done), .root_node(root_node), .node_count(node_count),
    .err_overflow(err_overflow), .sum_sat(sum_sat)
  );

  initial begin
    clk = 0;
    forever #5 clk = ~clk;
  end

  initial begin
    #500us;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", nm, act, exp);
  endtask

  function automatic logic [9:0] ent(input logic [8:0] e);
    return e[8] ? 10'(256 + int'(e[7:0])) : 10'(e[7:0]);
  endfunction

  function automatic logic [8:0] rnd_ent();
    logic [8:0] e;
    do e = 9'($urandom_range(0, 511)); while (e == NONE);
    return e;
  endfunction

  function automatic logic [63:0] rnd_sum();
    logic [63:0] s;
    s = {$urandom, $urandom};
    if ($urandom_range(0, 3) != 0) s[63:46] = '0;
    return s;
  endfunction

  task automatic m_reset();
    m_count = 0;
    m_done = 0;
    m_root = NONE;
    m_err = 0;
    m_sat = 0;
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, "_wr_en"}, 64'(mem_wr_en), 64'd0);
    chk({tag, "_fin"}, 64'(fin_state), 64'd0);
    chk({tag, "_tree_done"}, 64'(tree_done), 64'd0);
    chk({tag, "_root"}, 64'(root_node), 64'(NONE));
    chk({tag, "_count"}, 64'(node_count), 64'd0);
    chk({tag, "_err"}, 64'(err_overflow), 64'd0);
    chk({tag, "_sat"}, 64'(sum_sat), 64'd0);
    chk({tag, "_addr"}, 64'(mem_addr), 64'd0);
    chk({tag, "_wdata"}, mem_wdata, 64'd0);
  endtask

  // mem_ack responder: per-request delay from the directed queue, else random or zero
  initial begin
    int pend;
    pend = -1;
    mem_ack = 0;
    forever begin
      @(posedge clk);
      #2;
      mem_ack = 0;
      if (rst || !mem_wr_en) begin
        pend = -1;
        if (!rst && spurious && $urandom_range(0, 3) == 0) mem_ack = 1;
      end else begin
        if (pend < 0) begin
          pend = delays.size() != 0 ? delays.pop_front() : rand_delay ? int'($urandom_range(0, 2)) : 0;
          extra += pend;
        end
        if (pend == 0) begin
          mem_ack = 1;
          pend = -1;
        end else pend--;
      end
    end
  end

  // monitor: request stability while waiting, and accepted writes against the scoreboard
  initial begin
    logic [73:0] e;
    logic [9:0] p_addr;
    logic [63:0] p_data;
    bit p_pend;
    p_pend = 0;
    p_addr = '0;
    p_data = '0;
    forever begin
      @(negedge clk);
      if (rst) p_pend = 0;
      else begin
        if (mem_wr_en && p_pend) begin
          chk("stable_addr", 64'(mem_addr), 64'(p_addr));
          chk("stable_data", mem_wdata, p_data);
        end
        if (mem_wr_en && mem_ack) begin
          if (exp_q.size() == 0) begin
            n_checks++;
            $display("FAIL unexpected_write: addr %h data %h, none expected", mem_addr, mem_wdata);
          end else begin
            e = exp_q.pop_front();
            chk("wr_addr", 64'(mem_addr), 64'(e[73:64]));
            chk("wr_data", mem_wdata, e[63:0]);
          end
        end
        p_pend = mem_wr_en && !mem_ack;
        p_addr = mem_addr;
        p_data = mem_wdata;
      end
    end
  end

  task automatic iter(input logic [8:0] a, input logic [8:0] b, input logic [63:0] s);
    int cyc;
    bit merge;
    logic [45:0] w;
    merge = !m_done && b != NONE && m_count < 128;
    if (!m_done && b == NONE) begin
      m_done = 1;
      m_root = a;
    end else if (!m_done && m_count == 128) m_err = 1;
    if (merge) begin
      w = s[45:0];
`ifdef T05_HTREE_SUM_SAT_EN
      if (s[63:46] != 0) begin
        w = '1;
        m_sat = 1;
      end
`endif
      exp_q.push_back({ent(a), 64'd0});
      exp_q.push_back({ent(b), 64'd0});
      exp_q.push_back({10'(512 + m_count), a, b, w});
      exp_q.push_back({10'(256 + m_count), s});
      m_count++;
    end
    @(posedge clk);
    #1;
    extra = 0;
    least1 = a;
    least2 = b;
    sum = s;
    en_state = 4'd3;
    cyc = 0;
    do begin
      @(posedge clk);
      cyc++;
      @(negedge clk);
    end while (!fin_state && cyc < 300);
    chk("fin_latency", 64'(cyc), 64'((merge ? 10 : 2) + extra));
    chk("node_count", 64'(node_count), 64'(m_count));
    chk("tree_done", 64'(tree_done), 64'(m_done));
    chk("root_node", 64'(root_node), 64'(m_root));
    chk("err_overflow", 64'(err_overflow), 64'(m_err));
    chk("sum_sat", 64'(sum_sat), 64'(m_sat));
    chk("writes_left", 64'(exp_q.size()), 64'd0);
    @(posedge clk);
    #1;
    en_state = 4'd0;
    @(posedge clk);
    @(negedge clk);
    chk("fin_clear", 64'(fin_state), 64'd0);
  endtask

  initial begin
    rst = 1;
    en_state = 0;
    least1 = 0;
    least2 = 0;
    sum = 0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk_reset("por");
    @(posedge clk);
    #1 rst = 0;
    iter(9'h041, 9'h042, 64'd7);
    iter(9'h100, 9'h043, 64'd10);
    delays = '{0, 0, 3, 0};
    iter(9'h055, 9'h102, 64'd123);
    iter(9'h0aa, 9'h0bb, 64'h0001_0000_0000_0000);
    // reset while WIPE2 waits for its ack
    @(posedge clk);
    #1;
    delays = '{0, 5};
    exp_q.push_back({10'h061, 64'd0});
    least1 = 9'h061;
    least2 = 9'h062;
    sum = 64'd3;
    en_state = 4'd3;
    repeat (5) @(posedge clk);
    #1;
    chk("wipe2_pending", 64'(mem_wr_en), 64'd1);
    chk("wipe2_addr", 64'(mem_addr), 64'h062);
    rst = 1;
    en_state = 0;
    delays.delete();
    chk("aborted_writes_left", 64'(exp_q.size()), 64'd0);
    exp_q.delete();
    m_reset();
    #1 chk_reset("mid");
    @(posedge clk);
    @(posedge clk);
    #1 rst = 0;
    iter(9'h070, 9'h071, 64'd9);
    rand_delay = 1;
    while (m_count < 128) iter(rnd_ent(), rnd_ent(), rnd_sum());
    iter(rnd_ent(), rnd_ent(), rnd_sum());
    iter(9'h101, NONE, 64'd0);
    iter(9'h033, 9'h034, 64'd5);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
